// File: rtl/data_mem_access_ctrl_if.sv
// Core/memory bus bundle for the data memory access controller.
// The controller connects through the slave modport; the core and the
// memory model together sit on the master side.
interface data_mem_access_ctrl_if;
  // Core request side
  logic        req_valid;
  logic        req_we;
  logic [2:0]  funct3_;
  logic [31:0] address_target;
  logic [3:0]  byte_ena;
  logic [31:0] store_data;
  logic        req_ready;
  logic        stall;
  // Memory side
  logic [31:0] mem_addr;
  logic [3:0]  mem_byte_ena;
  logic [31:0] mem_wdata;
  logic        mem_we;
  logic        mem_re;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  // Load response side
  logic [31:0] load_data;
  logic        load_valid;
  logic        access_err;

  modport slave (
    input  req_valid, req_we, funct3_, address_target, byte_ena, store_data,
    input  mem_rdata, mem_ack,
    output req_ready, stall,
    output mem_addr, mem_byte_ena, mem_wdata, mem_we, mem_re,
    output load_data, load_valid, access_err
  );

  modport master (
    output req_valid, req_we, funct3_, address_target, byte_ena, store_data,
    output mem_rdata, mem_ack,
    input  req_ready, stall,
    input  mem_addr, mem_byte_ena, mem_wdata, mem_we, mem_re,
    input  load_data, load_valid, access_err
  );
endinterface

// File: rtl/data_mem_access_ctrl.sv
// Data memory access controller: accepts one RV32I load/store at a time,
// drives a word-addressed memory strobe until mem_ack (or a timeout), and
// returns extracted/extended load data or an error pulse through a
// one-cycle response state.
module data_mem_access_ctrl #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  reset,
  data_mem_access_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WR_WAIT = 2'd1,
    RD_WAIT = 2'd2,
    RESP    = 2'd3
  } state_t;

  localparam logic [7:0] TO_LIMIT = TIMEOUT_CYCLES[7:0];

  state_t      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [1:0]  off_q, off_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] wdata_q, wdata_d;
  logic [2:0]  f3_q, f3_d;
  logic [7:0]  tcnt_q, tcnt_d;
  logic [31:0] load_data_q, load_data_d;
  logic        resp_load_q, resp_load_d;
  logic        resp_err_q, resp_err_d;

  logic        req_legal;
  logic        req_misaligned;

  // Pick the addressed byte/halfword out of the big-endian lane layout
  // (offset 0 lives in bits 31:24) and extend it according to funct3.
  function automatic logic [31:0] extract_load(input logic [2:0]  f3,
                                               input logic [1:0]  off,
                                               input logic [31:0] rd);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    logic signed [31:0] b_sx;
    logic signed [31:0] h_sx;
    logic [31:0]        res;
    case (off)
      2'd0:    b = rd[31:24];
      2'd1:    b = rd[23:16];
      2'd2:    b = rd[15:8];
      default: b = rd[7:0];
    endcase
    h    = off[1] ? rd[15:0] : rd[31:16];
    b_sx = b;
    h_sx = h;
    case (f3)
      3'b000:  res = b_sx;
      3'b100:  res = {24'd0, b};
      3'b001:  res = h_sx;
      3'b101:  res = {16'd0, h};
      default: res = rd;
    endcase
    return res;
  endfunction

  // Classify the incoming request: funct3 legality and natural alignment.
  always_comb begin
    req_legal      = 1'b0;
    req_misaligned = 1'b0;
    if (bus.req_we) begin
      req_legal = (bus.funct3_ == 3'b000) || (bus.funct3_ == 3'b001) ||
                  (bus.funct3_ == 3'b010);
    end else begin
      req_legal = (bus.funct3_ == 3'b000) || (bus.funct3_ == 3'b001) ||
                  (bus.funct3_ == 3'b010) || (bus.funct3_ == 3'b100) ||
                  (bus.funct3_ == 3'b101);
    end
    if (bus.funct3_[1:0] == 2'b01) begin
      req_misaligned = bus.address_target[0];
    end else if (bus.funct3_[1:0] == 2'b10) begin
      req_misaligned = (bus.address_target[1:0] != 2'b00);
    end
  end

  // Next-state, datapath latches, timeout counting and output decode.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    off_d       = off_q;
    be_d        = be_q;
    wdata_d     = wdata_q;
    f3_d        = f3_q;
    tcnt_d      = tcnt_q;
    load_data_d = load_data_q;
    resp_load_d = resp_load_q;
    resp_err_d  = resp_err_q;

    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          tcnt_d      = 8'd0;
          resp_load_d = 1'b0;
          if (!req_legal || req_misaligned) begin
            // Errors skip the memory entirely and report from RESP.
            resp_err_d = 1'b1;
            state_d    = RESP;
          end else begin
            resp_err_d = 1'b0;
            addr_d     = {bus.address_target[31:2], 2'b00};
            off_d      = bus.address_target[1:0];
            f3_d       = bus.funct3_;
            if (bus.req_we) begin
              be_d    = bus.byte_ena;
              wdata_d = bus.store_data;
              state_d = WR_WAIT;
            end else begin
              state_d = RD_WAIT;
            end
          end
        end
      end
      WR_WAIT, RD_WAIT: begin
        // An ack in the same cycle the count would expire still wins.
        if (bus.mem_ack) begin
          state_d = RESP;
          if (state_q == RD_WAIT) begin
            load_data_d = extract_load(f3_q, off_q, bus.mem_rdata);
            resp_load_d = 1'b1;
          end
        end else begin
          tcnt_d = tcnt_q + 8'd1;
          if (tcnt_d == TO_LIMIT) begin
            resp_err_d = 1'b1;
            state_d    = RESP;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    bus.req_ready    = (state_q == IDLE);
    bus.stall        = (state_q != IDLE) || bus.req_valid;
    bus.mem_addr     = addr_q;
    bus.mem_wdata    = wdata_q;
    bus.mem_we       = (state_q == WR_WAIT);
    bus.mem_re       = (state_q == RD_WAIT);
    bus.mem_byte_ena = 4'b0000;
    if (state_q == WR_WAIT) begin
      bus.mem_byte_ena = be_q;
    end else if (state_q == RD_WAIT) begin
      bus.mem_byte_ena = 4'b1111;
    end
    bus.load_data    = load_data_q;
    bus.load_valid   = (state_q == RESP) && resp_load_q;
    bus.access_err   = (state_q == RESP) && resp_err_q;
  end

  // State and datapath registers; reset clears everything, even mid-access.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      addr_q      <= 32'd0;
      off_q       <= 2'd0;
      be_q        <= 4'd0;
      wdata_q     <= 32'd0;
      f3_q        <= 3'd0;
      tcnt_q      <= 8'd0;
      load_data_q <= 32'd0;
      resp_load_q <= 1'b0;
      resp_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      off_q       <= off_d;
      be_q        <= be_d;
      wdata_q     <= wdata_d;
      f3_q        <= f3_d;
      tcnt_q      <= tcnt_d;
      load_data_q <= load_data_d;
      resp_load_q <= resp_load_d;
      resp_err_q  <= resp_err_d;
    end
  end

endmodule

// File: tb/tb_data_mem_access_ctrl.sv
// Bench for data_mem_access_ctrl: directed load/store vectors, a
// transaction-timeline model checked every cycle, and literal expectations
// at each response cycle.
module tb_data_mem_access_ctrl;

  localparam int TO = 5;

  logic clk = 1'b0;
  logic reset;

  data_mem_access_ctrl_if bus ();

  data_mem_access_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] sd;
    logic [31:0] rd;
    int          ack_dly;   // cycles after acceptance; 0 = never acked
    logic [31:0] exp_ld;
    logic        exp_lv;
    logic        exp_err;
  } txn_t;

  txn_t vecs[$];

  // Model of the transaction in flight (one at a time)
  bit          m_active = 1'b0;
  int          m_c, m_end, m_resp;
  bit          m_err, m_to, m_we, m_ld_ok;
  logic [31:0] m_addr, m_sd, m_ld_new;
  logic [31:0] m_ld_base = 32'd0;
  logic [3:0]  m_be;
  int          m_rst_at = 2;
  bit          chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cycle=%0d got=%h want=%h", name, cyc, act, exp);
    end
  endtask

  // Load result from shift/mask arithmetic on the lane layout.
  function automatic logic [31:0] model_ext(input logic [2:0] f3, input logic [1:0] off,
                                            input logic [31:0] rd);
    int          sh;
    int          w;
    logic [31:0] v;
    logic [31:0] mask;
    if (f3[1:0] == 2'b00) begin
      w  = 8;
      sh = 8 * (3 - int'(off));
    end else if (f3[1:0] == 2'b01) begin
      w  = 16;
      sh = 16 - 8 * int'(off);
    end else begin
      return rd;
    end
    mask = (32'h1 << w) - 32'h1;
    v    = (rd >> sh) & mask;
    if (!f3[2] && v[w-1]) v = v | ~mask;
    return v;
  endfunction

  task automatic model_accept(input txn_t t, input int c);
    bit legal, mis;
    if (m_active && m_ld_ok) m_ld_base = m_ld_new;
    if (t.we) legal = (t.f3 == 3'b000) || (t.f3 == 3'b001) || (t.f3 == 3'b010);
    else      legal = (t.f3 == 3'b000) || (t.f3 == 3'b001) || (t.f3 == 3'b010) ||
                      (t.f3 == 3'b100) || (t.f3 == 3'b101);
    mis = ((t.f3[1:0] == 2'b01) && t.addr[0]) ||
          ((t.f3[1:0] == 2'b10) && (t.addr[1:0] != 2'b00));
    m_err  = !legal || mis;
    m_c    = c;
    m_we   = t.we;
    m_addr = {t.addr[31:2], 2'b00};
    m_be   = t.be;
    m_sd   = t.sd;
    m_to   = 1'b0;
    if (m_err) begin
      m_end = c;
    end else if (t.ack_dly >= 1 && t.ack_dly <= TO) begin
      m_end = c + t.ack_dly;
    end else begin
      m_end = c + TO;
      m_to  = 1'b1;
    end
    m_resp   = m_end + 1;
    m_ld_new = model_ext(t.f3, t.addr[1:0], t.rd);
    m_ld_ok  = !m_err && !m_to && !t.we;
    m_active = 1'b1;
  endtask

  // Per-cycle comparison of every output against the model timeline.
  always @(negedge clk) begin
    bit          strobe, busy, lv, er;
    logic [31:0] eld;
    if (cyc == m_rst_at) begin
      m_active  = 1'b0;
      m_ld_ok   = 1'b0;
      m_ld_base = 32'd0;
      chk_en    = 1'b1;
      chk("rst_mem_addr", bus.mem_addr, 32'd0);
      chk("rst_mem_wdata", bus.mem_wdata, 32'd0);
      chk("rst_mem_byte_ena", {28'd0, bus.mem_byte_ena}, 32'd0);
    end
    if (chk_en) begin
      strobe = m_active && !m_err && (cyc >= m_c + 1) && (cyc <= m_end);
      busy   = m_active && (cyc >= m_c + 1) && (cyc <= m_resp);
      lv     = m_active && (cyc == m_resp) && m_ld_ok;
      er     = m_active && (cyc == m_resp) && (m_err || m_to);
      eld    = (m_active && m_ld_ok && cyc >= m_resp) ? m_ld_new : m_ld_base;
      chk("req_ready", {31'd0, bus.req_ready}, {31'd0, !busy});
      chk("stall", {31'd0, bus.stall}, {31'd0, busy || bus.req_valid});
      chk("mem_we", {31'd0, bus.mem_we}, {31'd0, strobe && m_we});
      chk("mem_re", {31'd0, bus.mem_re}, {31'd0, strobe && !m_we});
      chk("load_valid", {31'd0, bus.load_valid}, {31'd0, lv});
      chk("access_err", {31'd0, bus.access_err}, {31'd0, er});
      chk("load_data", bus.load_data, eld);
      if (strobe) begin
        chk("mem_addr", bus.mem_addr, m_addr);
        chk("mem_byte_ena", {28'd0, bus.mem_byte_ena}, {28'd0, m_we ? m_be : 4'b1111});
        if (m_we) chk("mem_wdata", bus.mem_wdata, m_sd);
      end
    end
  end

  task automatic drive_req(input txn_t t);
    bus.req_valid      = 1'b1;
    bus.req_we         = t.we;
    bus.funct3_        = t.f3;
    bus.address_target = t.addr;
    bus.byte_ena       = t.be;
    bus.store_data     = t.sd;
    bus.mem_rdata      = t.rd;
    bus.mem_ack        = 1'b1;   // stray ack while idle must be ignored
  endtask

  task automatic run_txn(input txn_t t);
    @(posedge clk); #1;
    drive_req(t);
    model_accept(t, cyc);
    while (cyc < m_resp) begin
      @(posedge clk); #1;
      bus.req_valid = 1'b0;
      // real ack at its delay; stray ack during the response cycle
      bus.mem_ack = ((t.ack_dly > 0) && (cyc == m_c + t.ack_dly)) || (cyc == m_resp);
    end
    @(negedge clk);
    chk("resp_load_data", bus.load_data, t.exp_ld);
    chk("resp_load_valid", {31'd0, bus.load_valid}, {31'd0, t.exp_lv});
    chk("resp_access_err", {31'd0, bus.access_err}, {31'd0, t.exp_err});
  endtask

  task automatic add(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                     input logic [3:0] be, input logic [31:0] sd, input logic [31:0] rd,
                     input int dly, input logic [31:0] eld, input logic elv, input logic eerr);
    txn_t t;
    t.we = we; t.f3 = f3; t.addr = addr; t.be = be; t.sd = sd; t.rd = rd;
    t.ack_dly = dly; t.exp_ld = eld; t.exp_lv = elv; t.exp_err = eerr;
    vecs.push_back(t);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog cycle=%0d got=timeout want=finish", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    txn_t t;
    reset              = 1'b1;
    bus.req_valid      = 1'b0;
    bus.req_we         = 1'b0;
    bus.funct3_        = 3'd0;
    bus.address_target = 32'd0;
    bus.byte_ena       = 4'd0;
    bus.store_data     = 32'd0;
    bus.mem_rdata      = 32'd0;
    bus.mem_ack        = 1'b1;   // pending ack across reset

    chk("model_lb",  model_ext(3'b000, 2'd3, 32'h123456F0), 32'hFFFFFFF0);
    chk("model_lbu", model_ext(3'b100, 2'd3, 32'h123456F0), 32'h000000F0);
    chk("model_lh",  model_ext(3'b001, 2'd0, 32'h80017FFF), 32'hFFFF8001);
    chk("model_lhu", model_ext(3'b101, 2'd2, 32'h80017FFF), 32'h00007FFF);

    //  we  f3      addr          be       sd            rd            dly exp_ld        lv   err
    add(1, 3'b000, 32'h00001001, 4'b0100, 32'h00AB0000, 32'h0,        1,  32'h00000000, 0,   0);
    add(0, 3'b000, 32'h00002003, 4'b0000, 32'h0,        32'h123456F0, 1,  32'hFFFFFFF0, 1,   0);
    add(0, 3'b100, 32'h00002003, 4'b0000, 32'h0,        32'h123456F0, 1,  32'h000000F0, 1,   0);
    add(0, 3'b001, 32'h00002000, 4'b0000, 32'h0,        32'h80017FFF, 2,  32'hFFFF8001, 1,   0);
    add(0, 3'b101, 32'h00002002, 4'b0000, 32'h0,        32'h80017FFF, 1,  32'h00007FFF, 1,   0);
    add(1, 3'b010, 32'h00003002, 4'b1111, 32'h11223344, 32'h0,        1,  32'h00007FFF, 0,   1);
    add(0, 3'b010, 32'h00004000, 4'b0000, 32'h0,        32'hDEADBEEF, 3,  32'hDEADBEEF, 1,   0);
    add(0, 3'b000, 32'h00005001, 4'b0000, 32'h0,        32'h00807F00, 1,  32'hFFFFFF80, 1,   0);
    add(0, 3'b011, 32'h00006000, 4'b0000, 32'h0,        32'h55555555, 1,  32'hFFFFFF80, 0,   1);
    add(1, 3'b100, 32'h00006000, 4'b1000, 32'hAA000000, 32'h0,        1,  32'hFFFFFF80, 0,   1);
    add(0, 3'b001, 32'h00007001, 4'b0000, 32'h0,        32'h12345678, 1,  32'hFFFFFF80, 0,   1);
    add(1, 3'b001, 32'h00007002, 4'b0011, 32'h00001234, 32'h0,        TO, 32'hFFFFFF80, 0,   0);
    add(0, 3'b010, 32'h00007F00, 4'b0000, 32'h0,        32'hCAFEF00D, 0,  32'hFFFFFF80, 0,   1);
    add(0, 3'b100, 32'h00008002, 4'b0000, 32'h0,        32'h1122C344, 1,  32'h000000C3, 1,   0);

    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    foreach (vecs[i]) run_txn(vecs[i]);

    // Load left waiting for an ack, then reset while in RD_WAIT.
    t.we = 0; t.f3 = 3'b010; t.addr = 32'h00009000; t.be = 0; t.sd = 0;
    t.rd = 32'h99999999; t.ack_dly = 0;
    @(posedge clk); #1;
    drive_req(t);
    model_accept(t, cyc);
    repeat (2) begin
      @(posedge clk); #1;
      bus.req_valid = 1'b0;
      bus.mem_ack   = 1'b0;
    end
    @(posedge clk); #1;
    reset       = 1'b1;
    bus.mem_ack = 1'b1;
    m_rst_at    = cyc + 1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", {31'd0, bus.req_ready}, 32'd1);
    chk("post_rst_load_data", bus.load_data, 32'd0);

    vecs.delete();
    add(0, 3'b000, 32'h0000A000, 4'b0000, 32'h0,        32'h7F000000, 1,  32'h0000007F, 1,   0);
    add(0, 3'b101, 32'h0000B002, 4'b0000, 32'h0,        32'h0000FFFE, TO, 32'h0000FFFE, 1,   0);
    foreach (vecs[i]) run_txn(vecs[i]);

    @(posedge clk); #1;
    bus.mem_ack = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/data_mem_access_ctrl.md
DATA_MEM_ACCESS_CTRL -- requirements
Module: data_mem_access_ctrl

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, 255, maximum cycles to wait for mem_ack before aborting (range 1..255).
REQ-002 The block SHALL use one clock and a synchronous, active-high reset, with ports as follows.
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- req_valid  in  1  core requests a memory access
- req_we  in  1  1=store, 0=load
- funct3_  in  3  RV32I load/store funct3
- address_target  in  32  byte address
- byte_ena  in  4  store lane enables from the store aligner; bit3 = offset 0
- store_data  in  32  lane-aligned store data; bits[31:24] = offset 0
- req_ready  out  1  controller idle, request accepted this cycle
- stall  out  1  core must hold the pipeline
- mem_addr  out  32  word address {address_target[31:2],2'b00}
- mem_byte_ena  out  4  lane enables to memory
- mem_wdata  out  32  write data to memory
- mem_we  out  1  write strobe
- mem_re  out  1  read strobe
- mem_rdata  in  32  read data, valid with mem_ack
- mem_ack  in  1  memory completion
- load_data  out  32  extracted and extended load result
- load_valid  out  1  one-cycle pulse, load_data valid
- access_err  out  1  one-cycle pulse, misaligned, illegal or timed-out access

Function
REQ-003 FSM states: IDLE, WR_WAIT, RD_WAIT, RESP.
REQ-004 In IDLE, req_ready=1. A request is accepted when req_valid=1.
REQ-005 Accepted legal store: latch address, byte_ena and store_data, then go to WR_WAIT. mem_we=1 and mem_byte_ena=latched byte_ena are held until mem_ack.
REQ-006 Accepted legal load: latch address and funct3_, then go to RD_WAIT. mem_re=1 and mem_byte_ena=4'b1111 are held until mem_ack.
REQ-007 Legal store funct3_: 000, 001, 010. Legal load funct3_: 000, 001, 010, 100, 101.
REQ-008 Misaligned access: halfword with address_target[0]=1, or word with address_target[1:0]!=0.
REQ-009 An illegal funct3_ or misaligned access SHALL NOT assert mem_we or mem_re. It pulses access_err for one cycle, in the cycle after acceptance, via RESP.
REQ-010 Load lane select follows the store lane mapping: offset 0 -> mem_rdata[31:24], 1 -> [23:16], 2 -> [15:8], 3 -> [7:0]. Halfword offset 0 -> [31:16], offset 2 -> [15:0].
REQ-011 Load extension:
- LB/LH sign-extend.
- LBU/LHU zero-extend.
- LW passes mem_rdata unchanged.
REQ-012 On mem_ack in WR_WAIT or RD_WAIT, go to RESP. For loads, register the extracted data into load_data.
REQ-013 RESP lasts exactly one cycle:
- load_valid=1 for loads.
- access_err=1 for error paths.
- Then return to IDLE.
REQ-014 Timeout counter:
- Cleared on acceptance.
- Increments each cycle in WR_WAIT or RD_WAIT without mem_ack.
- On reaching TIMEOUT_CYCLES: deassert strobes, go to RESP with access_err=1 and load_valid=0.
REQ-015 mem_ack in the same cycle the count reaches TIMEOUT_CYCLES SHALL be treated as success.
REQ-016 mem_ack while in IDLE or RESP SHALL be ignored.
REQ-017 stall = (state != IDLE) or (req_valid and state == IDLE). req_valid is not accepted outside IDLE.
REQ-018 load_data SHALL hold its last value until the next load completes.
REQ-019 Minimum latency: acceptance to load_valid is 2 cycles when mem_ack returns the cycle after acceptance.

Reset
REQ-020 Reset while asserted SHALL force all of the following, even mid-transaction:
- state=IDLE
- req_ready=1
- mem_we=0, mem_re=0, mem_byte_ena=0, mem_wdata=0, mem_addr=0
- load_data=0, load_valid=0, access_err=0
- timeout counter=0
REQ-021 A pending mem_ack after reset SHALL be ignored.

Verification
REQ-022 SB: addr 0x1001, byte_ena 0100, store_data 0x00AB0000, ack after 1 cycle -> mem_addr 0x1000, mem_we=1 with byte_ena 0100 for one cycle, no access_err.
REQ-023 LB: addr 0x2003, mem_rdata 0x123456F0 -> load_data 0xFFFFFFF0, load_valid pulse. Same access as LBU -> 0x000000F0.
REQ-024 LH: addr 0x2000, mem_rdata 0x8001_7FFF -> load_data 0xFFFF8001. LHU at 0x2002 -> 0x00007FFF.
REQ-025 SW at addr 0x3002 -> no mem_we, access_err pulse one cycle later, back to IDLE.
REQ-026 LW with no mem_ack -> access_err after TIMEOUT_CYCLES. Reset asserted in RD_WAIT -> outputs at reset values on the next cycle.
